// File: rtl/niosii_irq_aggregator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : niosii_irq_pkg
// Description : Register map, field constants and active-source encoder for
//               the interrupt aggregator.
// Revision    : 1.0
// ============================================================================
package niosii_irq_pkg;

   localparam logic [2:0] ADDR_PENDING  = 3'd0;
   localparam logic [2:0] ADDR_MASK     = 3'd1;
   localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
   localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
   localparam logic [2:0] ADDR_FORCE    = 3'd4;
   localparam logic [2:0] ADDR_COUNT    = 3'd5;

   localparam int ACTIVE_VALID_BIT = 15;
   localparam int ID_W             = 4;
   localparam int MAX_SRC          = 15;

   // Returns {valid, id} where id is the lowest set bit index.
   function automatic logic [ID_W:0] prio_enc(input logic [MAX_SRC-1:0] v);
      logic [ID_W:0] r;
      r = '0;
      for (int i = MAX_SRC - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = {1'b1, i[ID_W-1:0]};
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/niosii_irq_aggregator_if.sv
`default_nettype none
// ============================================================================
// Module      : niosii_irq_aggregator_if
// Description : Avalon-MM slave register port of the interrupt aggregator.
// Revision    : 1.0
// ============================================================================
interface niosii_irq_aggregator_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface
`default_nettype wire

// File: rtl/niosii_irq_aggregator_src_sync.sv
`default_nettype none
// ============================================================================
// Module      : niosii_irq_src_sync
// Description : Per-source synchroniser with a delayed copy for rise detection.
// Revision    : 1.0
// ============================================================================
module niosii_irq_src_sync
   import niosii_irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  wire  clk,
   input  wire  reset_n,
   input  wire  i_d,
   output logic o_s,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
         r_s_d  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_s_d  <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_s    = r_sync[SYNC_STAGES-1];
   assign o_rise = r_sync[SYNC_STAGES-1] & ~r_s_d;

endmodule
`default_nettype wire

// File: rtl/niosii_irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : niosii_irq_aggregator
// Description : Avalon-MM interrupt aggregator: sync, edge/level pending,
//               mask, force and priority-encoded active ID. Optional event
//               counter at address 5 when NIOSII_IRQ_AGG_COUNT_EN is defined.
// Revision    : 1.0
// ============================================================================
module niosii_irq_aggregator
   import niosii_irq_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  wire                  clk,
   input  wire                  reset_n,
   niosii_irq_aggregator_if.slave bus,
   input  wire  [NUM_SRC-1:0]   irq_in,
   output logic                 irq
);

   logic [NUM_SRC-1:0] w_s;
   logic [NUM_SRC-1:0] w_rise;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_mask;
   logic [NUM_SRC-1:0] r_edge_sel;
   logic [NUM_SRC-1:0] w_wdata;
   logic [NUM_SRC-1:0] w_w1c;
   logic [NUM_SRC-1:0] w_force;
   logic [NUM_SRC-1:0] w_enter;
   logic [NUM_SRC-1:0] w_set;
   logic [NUM_SRC-1:0] w_pending_nxt;
   logic [ID_W:0]      w_act;
   logic [15:0]        w_rd_nxt;
   logic               w_wr;
   logic               w_unused;

   generate
      for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
         niosii_irq_src_sync #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .i_d     (irq_in[i]),
            .o_s     (w_s[i]),
            .o_rise  (w_rise[i])
         );
      end
   endgenerate

   assign w_wr     = bus.chipselect & ~bus.write_n;
   assign w_wdata  = bus.writedata[NUM_SRC-1:0];
   assign w_unused = &{1'b0, bus.writedata};
   assign w_w1c    = (w_wr && bus.address == ADDR_PENDING) ? w_wdata : '0;
   assign w_force  = (w_wr && bus.address == ADDR_FORCE)   ? w_wdata : '0;
   // Bits switching level->edge start edge mode with pending cleared.
   assign w_enter  = (w_wr && bus.address == ADDR_EDGE_SEL) ? (w_wdata & ~r_edge_sel) : '0;
   assign w_set    = r_edge_sel & (w_rise | w_force);

   // Set beats W1C; level bits simply follow the synchronised input.
   assign w_pending_nxt = ((r_edge_sel & (w_set | (r_pending & ~w_w1c)))
                          | (~r_edge_sel & w_s)) & ~w_enter;

   assign w_act = prio_enc(MAX_SRC'(r_pending & r_mask));

`ifdef NIOSII_IRQ_AGG_COUNT_EN
   logic [15:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 16'h0000;
      end else if (w_wr && bus.address == ADDR_COUNT) begin
         r_count <= 16'h0000;
      end else if (|w_set && r_count != 16'hFFFF) begin
         r_count <= r_count + 16'd1;
      end
   end
`endif

   always_comb begin
      w_rd_nxt = 16'h0000;
      case (bus.address)
         ADDR_PENDING:  w_rd_nxt[NUM_SRC-1:0] = r_pending;
         ADDR_MASK:     w_rd_nxt[NUM_SRC-1:0] = r_mask;
         ADDR_EDGE_SEL: w_rd_nxt[NUM_SRC-1:0] = r_edge_sel;
         ADDR_ACTIVE: begin
            if (w_act[ID_W]) begin
               w_rd_nxt[ACTIVE_VALID_BIT] = 1'b1;
               w_rd_nxt[ID_W-1:0]         = w_act[ID_W-1:0];
            end
         end
`ifdef NIOSII_IRQ_AGG_COUNT_EN
         ADDR_COUNT:    w_rd_nxt = r_count;
`endif
         default:       w_rd_nxt = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pending    <= '0;
         r_mask       <= '0;
         r_edge_sel   <= '0;
         irq          <= 1'b0;
         bus.readdata <= 16'h0000;
      end else begin
         r_pending    <= w_pending_nxt;
         if (w_wr && bus.address == ADDR_MASK) begin
            r_mask <= w_wdata;
         end
         if (w_wr && bus.address == ADDR_EDGE_SEL) begin
            r_edge_sel <= w_wdata;
         end
         irq          <= |(r_pending & r_mask);
         bus.readdata <= w_rd_nxt;
      end
   end

endmodule
`default_nettype wire
